// File: rtl/sl_bus_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// sl_bus_arbiter_pkg
//
// Shared definitions for the slave-bus round-robin arbiter:
//   - arb_state_e : FSM state encoding (IDLE=0, GRANT=1, TURN=2). These values
//                   are visible on the debug port, so keep them stable.
//   - ARB_N_MIN / ARB_N_MAX : supported requester count range.
// -----------------------------------------------------------------------------
package sl_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_TURN  = 2'd2
    } arb_state_e;

    localparam int ARB_N_MIN = 2;
    localparam int ARB_N_MAX = 16;

endpackage : sl_bus_arbiter_pkg

// File: rtl/sl_bus_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// sl_bus_arbiter_rr_pick
//
// Combinational round-robin finder. It returns the first set bit of
// eligible_i, searching upward from ptr_i+1 and wrapping modulo N. It works in
// three steps: rotate eligible_i so that bit ptr_i+1 lands at position 0,
// priority-encode the lowest set bit, then un-rotate the offset back to an
// absolute index.
//
// Ports:
//   eligible_i [N]    candidate requesters
//   ptr_i      [IDW]  index of the previous owner (the search starts after it)
//   found_o           at least one eligible bit was set
//   idx_o      [IDW]  absolute index of the winner (0 when found_o=0)
// -----------------------------------------------------------------------------
module sl_bus_arbiter_rr_pick #(
    parameter int N   = 4,
    parameter int IDW = $clog2(N)
) (
    input  logic [N-1:0]   eligible_i,
    input  logic [IDW-1:0] ptr_i,
    output logic           found_o,
    output logic [IDW-1:0] idx_o
);

    logic [N-1:0]   rot;
    logic [IDW-1:0] off;
    int             start;

    always_comb begin
        start = (int'(ptr_i) + 1) % N;

        // rot[0] corresponds to requester ptr+1, rot[N-1] to requester ptr.
        for (int i = 0; i < N; i++) begin
            rot[i] = eligible_i[(start + i) % N];
        end

        // Lowest set bit wins. Scanning downward lets the last hit stand
        // without needing an early exit.
        found_o = 1'b0;
        off     = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) begin
                found_o = 1'b1;
                off     = IDW'(i);
            end
        end

        idx_o = found_o ? IDW'((start + int'(off)) % N) : '0;
    end

endmodule : sl_bus_arbiter_rr_pick

// File: rtl/sl_bus_arbiter.sv
// -----------------------------------------------------------------------------
// sl_bus_arbiter
//
// Round-robin arbiter for the shared slave output bus. Up to N bus-interface
// instances each raise arb_request_i[i]. The arbiter answers with a one-hot
// registered arb_grant_o[i] that is held for the whole transfer. A single
// dead cycle (TURN) separates consecutive owners.
//
// Request/grant protocol: a request is a level, held high for the whole
// transfer. A grant answers an eligible request one cycle after it is sampled
// and stays high until the owner drops its request, the owner loses its enable,
// or the hold timeout fires. The grant then falls on the cycle after that event
// is sampled. Requests from non-owners never disturb a live grant.
//
// Timeout: after MAX_HOLD consecutive grant cycles (MAX_HOLD != 0), the grant is
// revoked, timeout_err_o pulses for one cycle together with the drop, and the
// owner is locked out. The lockout lasts until its request is seen low.
//
// Ports:
//   clk, reset         clock; synchronous active-high reset
//   arb_request_i [N]  per-requester request level
//   cfg_enable_i  [N]  per-requester enable mask
//   arb_grant_o   [N]  one-hot-or-zero grant (registered)
//   grant_valid_o      OR of arb_grant_o (registered)
//   grant_id_o    [ID] current owner index, 0 when no grant
//   timeout_err_o      one-cycle pulse on timeout revocation
//   timeout_id_o  [ID] owner that last timed out (held)
//   dbg_state_o        current FSM state
//   dbg_lockout_o [N]  lockout register
//   dbg_hold_cnt_o     current hold counter
// -----------------------------------------------------------------------------
module sl_bus_arbiter
    import sl_bus_arbiter_pkg::*;
#(
    parameter int N        = 4,
    parameter int MAX_HOLD = 1024,
    parameter int HOLD_W   = 11
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N-1:0]           arb_request_i,
    input  logic [N-1:0]           cfg_enable_i,
    output logic [N-1:0]           arb_grant_o,
    output logic                   grant_valid_o,
    output logic [$clog2(N)-1:0]   grant_id_o,
    output logic                   timeout_err_o,
    output logic [$clog2(N)-1:0]   timeout_id_o,
    output arb_state_e             dbg_state_o,
    output logic [N-1:0]           dbg_lockout_o,
    output logic [HOLD_W-1:0]      dbg_hold_cnt_o
);

    localparam int IDW = $clog2(N);

    // Last grant cycle before a forced revoke. This value is unused when
    // MAX_HOLD = 0.
    localparam logic [HOLD_W-1:0] HOLD_LAST =
        HOLD_W'((MAX_HOLD == 0) ? 0 : (MAX_HOLD - 1));

    // ------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------
    arb_state_e        state_q,   state_d;
    logic [IDW-1:0]    ptr_q,     ptr_d;
    logic [HOLD_W-1:0] hold_q,    hold_d;
    logic [N-1:0]      lockout_q, lockout_d;
    logic [N-1:0]      grant_q,   grant_d;
    logic              valid_q,   valid_d;
    logic [IDW-1:0]    gid_q,     gid_d;     // owner index while in GRANT
    logic              terr_q,    terr_d;
    logic [IDW-1:0]    tid_q,     tid_d;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    logic [N-1:0]   eligible;
    logic           pick_found;
    logic [IDW-1:0] pick_idx;
    logic           owner_req;
    logic           owner_en;
    logic           timeout_hit;

    assign eligible = arb_request_i & cfg_enable_i & ~lockout_q;

    sl_bus_arbiter_rr_pick #(
        .N   (N),
        .IDW (IDW)
    ) u_rr_pick (
        .eligible_i (eligible),
        .ptr_i      (ptr_q),
        .found_o    (pick_found),
        .idx_o      (pick_idx)
    );

    assign owner_req   = arb_request_i[gid_q];
    assign owner_en    = cfg_enable_i[gid_q];
    assign timeout_hit = (MAX_HOLD != 0) && (hold_q == HOLD_LAST);

    // ------------------------------------------------------------------
    // Next-state / output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        // A requester leaves lockout on any cycle its request is seen low.
        lockout_d = lockout_q & arb_request_i;
        grant_d   = grant_q;
        valid_d   = valid_q;
        gid_d     = gid_q;
        terr_d    = 1'b0;
        tid_d     = tid_q;

        unique case (state_q)
            ST_IDLE, ST_TURN: begin
                hold_d = '0;
                if (pick_found) begin
                    state_d = ST_GRANT;
                    ptr_d   = pick_idx;
                    gid_d   = pick_idx;
                    grant_d = N'(1) << pick_idx;
                    valid_d = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                    valid_d = 1'b0;
                    gid_d   = '0;
                end
            end

            ST_GRANT: begin
                // A voluntary release or a disable takes precedence over a
                // timeout in the same cycle. In that case no error is raised.
                if (!owner_req || !owner_en) begin
                    state_d = ST_TURN;
                    grant_d = '0;
                    valid_d = 1'b0;
                    gid_d   = '0;
                    hold_d  = '0;
                end else if (timeout_hit) begin
                    state_d          = ST_TURN;
                    grant_d          = '0;
                    valid_d          = 1'b0;
                    gid_d            = '0;
                    hold_d           = '0;
                    terr_d           = 1'b1;
                    tid_d            = gid_q;
                    lockout_d[gid_q] = 1'b1;
                end else if (hold_q != '1) begin
                    // Saturate so MAX_HOLD=0 can hold the bus indefinitely.
                    hold_d = hold_q + 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
                valid_d = 1'b0;
                gid_d   = '0;
                hold_d  = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            ptr_q     <= IDW'(N - 1);
            hold_q    <= '0;
            lockout_q <= '0;
            grant_q   <= '0;
            valid_q   <= 1'b0;
            gid_q     <= '0;
            terr_q    <= 1'b0;
            tid_q     <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            hold_q    <= hold_d;
            lockout_q <= lockout_d;
            grant_q   <= grant_d;
            valid_q   <= valid_d;
            gid_q     <= gid_d;
            terr_q    <= terr_d;
            tid_q     <= tid_d;
        end
    end

    assign arb_grant_o    = grant_q;
    assign grant_valid_o  = valid_q;
    assign grant_id_o     = gid_q;
    assign timeout_err_o  = terr_q;
    assign timeout_id_o   = tid_q;
    assign dbg_state_o    = state_q;
    assign dbg_lockout_o  = lockout_q;
    assign dbg_hold_cnt_o = hold_q;

endmodule : sl_bus_arbiter

// File: tb/tb_sl_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sl_bus_arbiter
//
// Bench for sl_bus_arbiter. The main instance uses N=4 and MAX_HOLD=16. A
// second instance uses MAX_HOLD=0 (timeout disabled). Each step() drives one
// cycle of inputs and pushes the hand-derived expected outputs for the
// following cycle onto exp_q. It then pops that entry and compares it against
// the outputs sampled on the falling edge.
//
// Expected word layout: {timeout_err, timeout_id[1:0], grant_valid,
//                        grant_id[1:0], arb_grant[3:0]}
// -----------------------------------------------------------------------------
module tb_sl_bus_arbiter;
    import sl_bus_arbiter_pkg::*;

    localparam int W = 10;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic [3:0] req;
    logic [3:0] en;
    logic       use_nh;
    logic [3:0] req_main;
    logic [3:0] req_nh;

    assign req_main = use_nh ? 4'b0000 : req;
    assign req_nh   = use_nh ? req : 4'b0000;

    logic [3:0]  grant_m, grant_n;
    logic        valid_m, valid_n;
    logic [1:0]  gid_m,   gid_n;
    logic        terr_m,  terr_n;
    logic [1:0]  tid_m,   tid_n;
    arb_state_e  state_m, state_n;
    logic [3:0]  lock_m,  lock_n;
    logic [4:0]  hold_m;
    logic [10:0] hold_n;

    sl_bus_arbiter #(
        .N        (4),
        .MAX_HOLD (16),
        .HOLD_W   (5)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .arb_request_i  (req_main),
        .cfg_enable_i   (en),
        .arb_grant_o    (grant_m),
        .grant_valid_o  (valid_m),
        .grant_id_o     (gid_m),
        .timeout_err_o  (terr_m),
        .timeout_id_o   (tid_m),
        .dbg_state_o    (state_m),
        .dbg_lockout_o  (lock_m),
        .dbg_hold_cnt_o (hold_m)
    );

    sl_bus_arbiter #(
        .N        (4),
        .MAX_HOLD (0),
        .HOLD_W   (11)
    ) dut_nh (
        .clk            (clk),
        .reset          (reset),
        .arb_request_i  (req_nh),
        .cfg_enable_i   (en),
        .arb_grant_o    (grant_n),
        .grant_valid_o  (valid_n),
        .grant_id_o     (gid_n),
        .timeout_err_o  (terr_n),
        .timeout_id_o   (tid_n),
        .dbg_state_o    (state_n),
        .dbg_lockout_o  (lock_n),
        .dbg_hold_cnt_o (hold_n)
    );

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    int           n_cmp = 0;
    int           n_bad = 0;
    int           exp_tid = 0;

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] mk_exp(input logic v, input int gid,
                                            input logic terr, input int tid);
        logic [3:0] g;
        logic [1:0] id;
        g  = v ? 4'(1 << gid) : 4'b0000;
        id = v ? 2'(gid) : 2'b00;
        return {terr, 2'(tid), v, id, g};
    endfunction

    function automatic logic [W-1:0] observed();
        if (use_nh) return {terr_n, tid_n, valid_n, gid_n, grant_n};
        return {terr_m, tid_m, valid_m, gid_m, grant_m};
    endfunction

    // ---------------- driver ----------------
    // Called on the falling edge. Drives one cycle of inputs, then checks the
    // outputs that the next rising edge produces.
    task automatic step(input logic rst, input logic [3:0] r, input logic [3:0] e,
                        input logic v, input int gid, input logic terr,
                        input string tag);
        logic [W-1:0] exp;
        reset = rst;
        req   = r;
        en    = e;
        exp_q.push_back(mk_exp(v, gid, terr, exp_tid));
        @(posedge clk);
        @(negedge clk);
        exp = exp_q.pop_front();
        check_eq(tag, 32'(observed()), 32'(exp));
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    int order[5] = '{0, 1, 2, 3, 0};
    int idle_gap;

    initial begin
        reset  = 1'b1;
        req    = 4'b0000;
        en     = 4'b1111;
        use_nh = 1'b0;

        // Reset state
        exp_tid = 0;
        step(1'b1, 4'b0000, 4'b1111, 1'b0, 0, 1'b0, "reset_out");
        step(1'b1, 4'b0000, 4'b1111, 1'b0, 0, 1'b0, "reset_out");
        check_eq("reset_state", 32'(state_m), 32'(ST_IDLE));
        check_eq("reset_lockout", 32'(lock_m), 32'h0);

        // Single request. A random idle gap is followed by a 10-cycle
        // transfer on requester 2.
        idle_gap = $urandom_range(3, 8);
        for (int i = 0; i < idle_gap; i++)
            step(1'b0, 4'b0000, 4'b1111, 1'b0, 0, 1'b0, "single_idle");
        for (int i = 0; i < 10; i++)
            step(1'b0, 4'b0100, 4'b1111, 1'b1, 2, 1'b0, "single_grant");
        check_eq("single_state", 32'(state_m), 32'(ST_GRANT));
        step(1'b0, 4'b0000, 4'b1111, 1'b0, 0, 1'b0, "single_release");
        check_eq("turn_state", 32'(state_m), 32'(ST_TURN));
        step(1'b0, 4'b0000, 4'b1111, 1'b0, 0, 1'b0, "single_idle2");

        // Round-robin. After a reset, all four requesters hold their
        // requests. Each owner keeps the grant for 3 cycles and then drops
        // its request for one cycle.
        exp_tid = 0;
        step(1'b1, 4'b0000, 4'b1111, 1'b0, 0, 1'b0, "rr_reset");
        for (int k = 0; k < 5; k++) begin
            for (int c = 0; c < 3; c++)
                step(1'b0, 4'b1111, 4'b1111, 1'b1, order[k], 1'b0, "rr_grant");
            step(1'b0, 4'b1111 & ~(4'b0001 << order[k]), 4'b1111,
                 1'b0, 0, 1'b0, "rr_dead");
        end
        step(1'b0, 4'b0000, 4'b1111, 1'b0, 0, 1'b0, "rr_idle");

        // Timeout. Requester 1 stays stuck high. The grant lasts exactly
        // 16 cycles, then timeout_err pulses and requester 1 is locked out.
        for (int i = 0; i < 16; i++)
            step(1'b0, 4'b0010, 4'b1111, 1'b1, 1, 1'b0, "to_grant");
        exp_tid = 1;
        step(1'b0, 4'b0010, 4'b1111, 1'b0, 0, 1'b1, "to_pulse");
        for (int i = 0; i < 3; i++)
            step(1'b0, 4'b0010, 4'b1111, 1'b0, 0, 1'b0, "to_lockout");
        check_eq("to_lock_reg", 32'(lock_m), 32'h2);
        step(1'b0, 4'b0000, 4'b1111, 1'b0, 0, 1'b0, "to_drop");
        step(1'b0, 4'b0010, 4'b1111, 1'b1, 1, 1'b0, "to_regrant");
        step(1'b0, 4'b0000, 4'b1111, 1'b0, 0, 1'b0, "to_release");

        // Enable mask, non-preemption, and revoke by disable
        for (int i = 0; i < 3; i++)
            step(1'b0, 4'b0100, 4'b1011, 1'b0, 0, 1'b0, "en_masked");
        step(1'b0, 4'b0001, 4'b1111, 1'b1, 0, 1'b0, "en_grant0");
        step(1'b0, 4'b1101, 4'b1111, 1'b1, 0, 1'b0, "en_nopreempt");
        step(1'b0, 4'b0001, 4'b1110, 1'b0, 0, 1'b0, "en_revoke");
        check_eq("en_revoke_state", 32'(state_m), 32'(ST_TURN));
        step(1'b0, 4'b0001, 4'b1110, 1'b0, 0, 1'b0, "en_disabled");
        step(1'b0, 4'b0001, 4'b1111, 1'b1, 0, 1'b0, "en_reenable");
        step(1'b0, 4'b0000, 4'b1111, 1'b0, 0, 1'b0, "en_release");

        // Reset mid-grant, then the first arbitration after reset
        step(1'b0, 4'b1000, 4'b1111, 1'b1, 3, 1'b0, "rm_grant3");
        step(1'b0, 4'b1000, 4'b1111, 1'b1, 3, 1'b0, "rm_grant3");
        exp_tid = 0;
        step(1'b1, 4'b1000, 4'b1111, 1'b0, 0, 1'b0, "rm_reset");
        check_eq("rm_state", 32'(state_m), 32'(ST_IDLE));
        step(1'b0, 4'b1010, 4'b1111, 1'b1, 1, 1'b0, "rm_first");
        step(1'b0, 4'b0000, 4'b1111, 1'b0, 0, 1'b0, "rm_release");

        // MAX_HOLD=0. A single requester holds the bus for 5000 cycles.
        use_nh  = 1'b1;
        exp_tid = 0;
        for (int i = 0; i < 5000; i++)
            step(1'b0, 4'b0001, 4'b1111, 1'b1, 0, 1'b0, "nh_hold");
        step(1'b0, 4'b0000, 4'b1111, 1'b0, 0, 1'b0, "nh_release");

        check_eq("queue_empty", 32'(exp_q.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_sl_bus_arbiter

// File: doc/sl_bus_arbiter.md
# sl_bus_arbiter

Round-robin arbiter that shares the single slave output bus (sl_addr/sl_tail/sl_data) between up to N bus-interface instances (EIN, PWM, GPIO, …), each presenting an sl_arb_request and receiving an sl_arb_grant. It holds a grant for the whole transfer and inserts one dead cycle between owners. It also enforces a per-grant hold timeout so a wedged requester cannot starve the bus. It sits at the top level between the slave-side bus_interface instances and the shared slave bus mux.

## Interface
- N, default 4: number of requesters, 2..16.
- MAX_HOLD, default 1024: maximum consecutive grant cycles per ownership; 0 disables the timeout.
- HOLD_W, default 11: hold-counter width; must satisfy 2^HOLD_W > MAX_HOLD.
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- arb_request  in  N  per-requester request; level, held for the whole transfer.
- cfg_enable  in  N  per-requester enable mask; 0 makes the requester ineligible.
- arb_grant  out  N  one-hot-or-zero grant, registered.
- grant_valid  out  1  OR of arb_grant, registered.
- grant_id  out  clog2(N)  index of the current owner; 0 when grant_valid=0.
- timeout_err  out  1  one-cycle pulse when a grant is revoked by timeout.
- timeout_id  out  clog2(N)  owner index that timed out; held until the next timeout.

## Operation
- eligible = arb_request & cfg_enable & ~lockout.
- States:
  - IDLE (0): no grant. If eligible≠0, pick the first set bit searching from ptr+1 mod N; go to GRANT.
  - GRANT (1): owner's arb_grant=1; hold_cnt increments each cycle.
  - TURN (2): all grants 0. Arbitrates exactly like IDLE, so the next grant can assert on the following cycle.
- GRANT exits to TURN on the first of:
  - owner's arb_request sampled 0;
  - owner's cfg_enable sampled 0 (revoked, no error);
  - hold_cnt==MAX_HOLD-1 with MAX_HOLD≠0 (timeout).
- On timeout:
  - timeout_err pulses together with the grant drop; timeout_id=owner.
  - lockout[owner] is set.
  - lockout[i] clears on any cycle where arb_request[i] is sampled 0.
- ptr is updated to the owner index when a grant is issued. After reset ptr=N-1, so requester 0 wins the first arbitration.
- Requests from non-owners never disturb the current grant; arbitration is non-preemptive.
- Reset values: state=IDLE, arb_grant=0, grant_valid=0, grant_id=0, timeout_err=0, timeout_id=0, lockout=0, hold_cnt=0, ptr=N-1.
- Reset mid-grant: grant drops in the cycle after reset is sampled; no timeout_err is generated.

## Timing
- Request-to-grant: eligible request sampled in cycle t while IDLE/TURN → arb_grant high in t+1.
- Release: owner request sampled low in cycle t → arb_grant low in t+1 (TURN) → next grant earliest in t+2. This guarantees exactly one dead bus cycle between owners.
- Grant duration under timeout: arb_grant is high for exactly MAX_HOLD cycles.
- A request that drops and re-rises within TURN competes normally in round-robin; the pointer has already moved past it.
- A requester that is both requesting and disabled is ignored; enabling it later makes it eligible from the next sample.
- N=1 is outside the parameter range; it need not be supported.

## Structure
- Shared include (ice_def.v): state encodings IDLE/TURN/GRANT, `SD` delay macro, clog2 function.
- Sub-module rr_pick: combinational round-robin finder.
  - Inputs: eligible[N], ptr.
  - Outputs: found, idx.
  - Implemented by rotate, priority-encode, un-rotate.
- The top FSM, hold counter, lockout register and output registers live in sl_bus_arbiter.

## Test plan
- Single request: N=4, after reset raise req[2] at cycle 10 → grant=4'b0100 at cycle 11, grant_id=2. Drop req at cycle 20 → grant=0 at cycle 21.
- Round-robin: req=4'b1111 held; each owner releases after 3 grant cycles → grant order 0,1,2,3,0, with one zero-grant cycle between owners.
- Timeout: MAX_HOLD=16, req[1] stuck high → grant[1] high for exactly 16 cycles, timeout_err pulse with timeout_id=1. req[1] not regranted until it drops for at least one cycle.
- Enable mask: cfg_enable=4'b1011 with req=4'b0100 → no grant. Clear cfg_enable[0] during grant to requester 0 → grant drops next cycle, timeout_err=0.
- Reset mid-grant: assert reset while grant[3]=1 → all outputs at reset values the next cycle. The first post-reset grant with req=4'b1010 goes to requester 1.
- MAX_HOLD=0: single requester held for 5000 cycles → grant stays high throughout, timeout_err never asserts.
